// File: rtl/basket_ledger_ctrl_if.sv
// Command, price-ROM and display-read signals between the basket controller
// and its neighbours. The controller uses the slave modport.
interface basket_ledger_ctrl_if #(
  parameter int ID_W    = 4,
  parameter int QTY_W   = 4,
  parameter int PRICE_W = 8,
  parameter int TOTAL_W = 16
);
  logic               ENABLE;
  logic [ID_W-1:0]    ProductID;
  logic [QTY_W-1:0]   Quantity;
  logic               CLEAR;
  logic [ID_W-1:0]    Price_addr;
  logic [PRICE_W-1:0] Price_in;
  logic [2:0]         Rd_idx;
  logic [ID_W-1:0]    Rd_ID;
  logic [QTY_W-1:0]   Rd_Qty;
  logic               BUSY;
  logic               ACK;
  logic               ERR;
  logic               FULL;
  logic [3:0]         ItemCount;
  logic [TOTAL_W-1:0] TotalPrice;
  logic               OVF;

  modport master (
    output ENABLE, ProductID, Quantity, CLEAR, Price_in, Rd_idx,
    input  Price_addr, Rd_ID, Rd_Qty, BUSY, ACK, ERR, FULL, ItemCount, TotalPrice, OVF
  );

  modport slave (
    input  ENABLE, ProductID, Quantity, CLEAR, Price_in, Rd_idx,
    output Price_addr, Rd_ID, Rd_Qty, BUSY, ACK, ERR, FULL, ItemCount, TotalPrice, OVF
  );
endinterface

// File: rtl/basket_ledger_ctrl.sv
// Basket ledger: compacted (ID, qty) table with add/update/remove commands and
// a saturating total recomputed through a 1-cycle-latency price ROM.
module basket_ledger_ctrl #(
  parameter int MAX_ITEMS    = 8,
  parameter int NUM_PRODUCTS = 12,
  parameter int ID_W         = 4,
  parameter int QTY_W        = 4,
  parameter int PRICE_W      = 8,
  parameter int TOTAL_W      = 16
) (
  input logic               CLOCK_50,
  input logic               RESET_N,
  basket_ledger_ctrl_if.slave bus
);

  localparam int IDX_W  = $clog2(MAX_ITEMS);
  localparam int PROD_W = PRICE_W + QTY_W;
  localparam int SUM_W  = TOTAL_W + PROD_W + 1;
  localparam logic [3:0]       MAX_CNT = 4'(MAX_ITEMS);
  localparam logic [SUM_W-1:0] SAT     = {{(PROD_W + 1){1'b0}}, {TOTAL_W{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_UPDATE,
    S_RECALC_ADDR,
    S_RECALC_ACC,
    S_DONE
  } state_t;

  state_t             state;
  logic [ID_W-1:0]    ids  [MAX_ITEMS];
  logic [QTY_W-1:0]   qtys [MAX_ITEMS];
  logic [3:0]         count;
  logic [3:0]         idx;
  logic [3:0]         ri;
  logic               hit;
  logic [ID_W-1:0]    cmd_id;
  logic [QTY_W-1:0]   cmd_qty;
  logic [TOTAL_W:0]   acc;
  logic [TOTAL_W-1:0] total;
  logic               ovf;
  logic               busy;
  logic               ack;
  logic               err;
  logic [ID_W-1:0]    addr_hold;

  logic [IDX_W-1:0]   idx_s;
  logic [IDX_W-1:0]   ri_s;
  logic [IDX_W-1:0]   cnt_s;
  logic [IDX_W-1:0]   rd_s;
  logic               rd_ok;
  logic [PROD_W-1:0]  prod;
  logic [SUM_W-1:0]   sum;

  assign idx_s = idx[IDX_W-1:0];
  assign ri_s  = ri[IDX_W-1:0];
  assign cnt_s = count[IDX_W-1:0];
  assign rd_s  = IDX_W'(bus.Rd_idx);
  assign rd_ok = {1'b0, bus.Rd_idx} < count;

  assign prod = PROD_W'(bus.Price_in) * PROD_W'(qtys[ri_s]);
  assign sum  = SUM_W'(acc) + SUM_W'(prod);

  // Address is presented combinationally in RECALC_ADDR so ROM data lands in RECALC_ACC.
  assign bus.Price_addr = (state == S_RECALC_ADDR && ri != count) ? ids[ri_s] : addr_hold;

  assign bus.Rd_ID      = rd_ok ? ids[rd_s]  : '0;
  assign bus.Rd_Qty     = rd_ok ? qtys[rd_s] : '0;
  assign bus.BUSY       = busy;
  assign bus.ACK        = ack;
  assign bus.ERR        = err;
  assign bus.FULL       = (count == MAX_CNT);
  assign bus.ItemCount  = count;
  assign bus.TotalPrice = total;
  assign bus.OVF        = ovf;

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state     <= S_IDLE;
      count     <= '0;
      idx       <= '0;
      ri        <= '0;
      hit       <= 1'b0;
      cmd_id    <= '0;
      cmd_qty   <= '0;
      acc       <= '0;
      total     <= '0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      ack       <= 1'b0;
      err       <= 1'b0;
      addr_hold <= '0;
      for (int unsigned j = 0; j < MAX_ITEMS; j++) begin
        ids[j]  <= '0;
        qtys[j] <= '0;
      end
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.CLEAR) begin
            count <= '0;
            total <= '0;
            ovf   <= 1'b0;
            busy  <= 1'b1;
            ack   <= 1'b1;
            state <= S_DONE;
          end else if (bus.ENABLE) begin
            cmd_id  <= bus.ProductID;
            cmd_qty <= bus.Quantity;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= S_SEARCH;
          end
        end

        S_SEARCH: begin
          if (idx == count) begin
            hit   <= 1'b0;
            state <= S_UPDATE;
          end else if (ids[idx_s] == cmd_id) begin
            hit   <= 1'b1;
            state <= S_UPDATE;
          end else begin
            idx <= idx + 4'd1;
          end
        end

        S_UPDATE: begin
          acc   <= '0;
          ri    <= '0;
          state <= S_RECALC_ADDR;
          if (32'(cmd_id) >= NUM_PRODUCTS) begin
            ack   <= 1'b1;
            err   <= 1'b1;
            state <= S_DONE;
          end else if (hit && cmd_qty != '0) begin
            qtys[idx_s] <= cmd_qty;
          end else if (hit) begin
            // Removal compacts the table in one cycle, preserving entry order.
            for (int unsigned j = 0; j < MAX_ITEMS - 1; j++) begin
              if (j >= 32'(idx)) begin
                ids[IDX_W'(j)]  <= ids[IDX_W'(j + 1)];
                qtys[IDX_W'(j)] <= qtys[IDX_W'(j + 1)];
              end
            end
            count <= count - 4'd1;
          end else if (cmd_qty != '0 && count != MAX_CNT) begin
            ids[cnt_s]  <= cmd_id;
            qtys[cnt_s] <= cmd_qty;
            count       <= count + 4'd1;
          end else if (cmd_qty != '0) begin
            ack   <= 1'b1;
            err   <= 1'b1;
            state <= S_DONE;
          end
        end

        S_RECALC_ADDR: begin
          if (ri == count) begin
            total <= acc[TOTAL_W-1:0];
            ack   <= 1'b1;
            state <= S_DONE;
          end else begin
            addr_hold <= ids[ri_s];
            state     <= S_RECALC_ACC;
          end
        end

        S_RECALC_ACC: begin
          if (sum > SAT) begin
            acc <= SAT[TOTAL_W:0];
            ovf <= 1'b1;
          end else begin
            acc <= sum[TOTAL_W:0];
          end
          ri    <= ri + 4'd1;
          state <= S_RECALC_ADDR;
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
